xor_txn_master: RTL and testbench
=================================

XOR_TXN_MASTER -- requirements
Module: xor_txn_master

Interface
REQ-001 Parameter: CNT_W, default 16, width of transaction count and pass/fail counters.
REQ-002 Parameter: QDEPTH, default 4, power of two; capacity of the expected-result queue (max outstanding transactions).
REQ-003 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  one-cycle pulse; begins a run.
REQ-006 Port: num_txn  input  CNT_W  transactions per run; sampled on accepted start.
REQ-007 Port: seed  input  8  LFSR seed; sampled on accepted start.
REQ-008 Port: wr_en  output  1  write strobe to the operand FIFO.
REQ-009 Port: din  output  2  operand pair {a,b} to the operand FIFO.
REQ-010 Port: full  input  1  operand FIFO full.
REQ-011 Port: rd_en  output  1  read strobe to the result FIFO.
REQ-012 Port: dout  input  1  result bit, first-word-fall-through (valid while empty=0).
REQ-013 Port: empty  input  1  result FIFO empty.
REQ-014 Port: busy  output  1  high in RUN or DRAIN.
REQ-015 Port: done  output  1  high in DONE.
REQ-016 Port: pass_cnt  output  CNT_W  matching results this run.
REQ-017 Port: fail_cnt  output  CNT_W  mismatching results this run.
REQ-018 Port: timeout  output  1  run ended by watchdog (see Configuration).

Function
REQ-019 States IDLE, RUN, DRAIN, DONE; start accepted only in IDLE or DONE, ignored otherwise.
REQ-020 Accepted start: clear sent/received/pass/fail counters, timeout, and queue; load LFSR with seed (8'h00 loads 8'h01); go RUN, or DONE next cycle if num_txn==0.
REQ-021 LFSR step: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; din = lfsr[1:0] combinationally.
REQ-022 wr_en = 1 iff state RUN, full==0, sent<num_txn, queue not full; wr_en never high while full==1.
REQ-023 On write: push din[1]^din[0] into queue, step LFSR, sent+1.
REQ-024 rd_en = 1 iff state RUN or DRAIN, empty==0, queue not empty.
REQ-025 On read: compare dout with queue head, pop, received+1; pass_cnt+1 on match else fail_cnt+1; both saturate at all-ones.
REQ-026 Simultaneous push and pop in one cycle: both occur; occupancy unchanged; pop of the entry pushed that same cycle is impossible (pop uses pre-push head).
REQ-027 Queue pointers wrap modulo QDEPTH; occupancy tracked with one extra bit to separate full from empty.
REQ-028 RUN -> DRAIN on the cycle sent reaches num_txn; DRAIN -> DONE on the cycle received reaches num_txn.
REQ-029 Result data arriving with queue empty is not read (rd_en stays 0).
REQ-030 pass_cnt, fail_cnt, timeout hold their values in DONE until next accepted start.

Reset
REQ-031 rst high at a clock edge: state IDLE; wr_en, rd_en, busy, done, timeout = 0; pass_cnt, fail_cnt, counters = 0; queue empty; LFSR = 8'h01.
REQ-032 rst mid-run aborts immediately; outstanding queue entries discarded; rst overrides a simultaneous start.

Configuration
REQ-033 Macro XOR_TXN_TIMEOUT_EN defined: 8-bit watchdog counts cycles in DRAIN without a read, cleared on each read; at 255 go DONE with timeout=1.
REQ-034 Macro XOR_TXN_TIMEOUT_EN undefined: no watchdog; DRAIN waits indefinitely; timeout tied 0; port list unchanged.

Verification
REQ-035 Ideal XOR-FIFO model, seed=8'hA5, num_txn=10, start -> 10 writes, din sequence matches LFSR, done=1, pass_cnt=10, fail_cnt=0.
REQ-036 Model inverts every third result, num_txn=9 -> pass_cnt=6, fail_cnt=3, done=1.
REQ-037 full held high 20 cycles mid-run, num_txn=8 -> wr_en 0 during full, no lost/duplicate writes, pass_cnt=8.
REQ-038 Result FIFO stalled (empty=1) -> at most QDEPTH=4 writes outstanding before wr_en drops; release -> run completes, pass_cnt=num_txn.
REQ-039 num_txn=0, start -> done=1 next cycle, no wr_en/rd_en pulses; rst asserted mid-run (num_txn=50, after 5 writes) -> all outputs reset values next cycle.
REQ-040 XOR_TXN_TIMEOUT_EN defined, model drops last result, num_txn=4 -> done=1, timeout=1, pass_cnt=3 after 255 idle DRAIN cycles.

Source files
------------

// File: rtl/xor_txn_master.sv
// Transaction master that streams LFSR operand pairs into an XOR FIFO and checks returned results.
// Optional watchdog on the drain phase is enabled by defining XOR_TXN_TIMEOUT_EN.
module xor_txn_master #(
  parameter int CNT_W  = 16,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_txn,
  input  logic [7:0]       seed,
  output logic             wr_en,
  output logic [1:0]       din,
  input  logic             full,
  output logic             rd_en,
  input  logic             dout,
  input  logic             empty,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             timeout
);

  // QDEPTH is a power of two >= 2, so pointers wrap for free at their natural width.
  localparam int AW = $clog2(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_num, r_sent, r_rcvd;
  logic [CNT_W-1:0] r_pass, r_fail;
  logic [7:0]       r_lfsr;
  logic [7:0]       w_lfsr_next;
  logic [QDEPTH-1:0] r_q;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_occ;
  logic             w_accept, w_q_full, w_q_empty;
  logic             w_push, w_pop, w_match;
  logic             w_sent_last, w_rcvd_last, w_wdog_exp;

  assign w_accept    = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_q_full    = (r_occ == (AW+1)'(QDEPTH));
  assign w_q_empty   = (r_occ == '0);
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign din         = r_lfsr[1:0];
  assign w_push      = wr_en;
  assign w_pop       = rd_en;
  assign w_match     = (dout == r_q[r_rptr]);
  assign w_sent_last = w_push && ((r_sent + 1'b1) == r_num);
  assign w_rcvd_last = w_pop && ((r_rcvd + 1'b1) == r_num);

`ifdef XOR_TXN_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_timeout;
  assign w_wdog_exp = (r_state == S_DRAIN) && (r_wdog == 8'hFF) && !w_pop;
  assign timeout    = r_timeout;

  // Watchdog only runs while draining; any read restarts it.
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_DRAIN) begin
      r_wdog <= w_pop ? 8'h00 : r_wdog + 8'h01;
      if (w_wdog_exp) r_timeout <= 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end
`else
  assign w_wdog_exp = 1'b0;
  assign timeout    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_next = (num_txn == '0) ? S_DONE : S_RUN;
      S_RUN:          if (w_sent_last) w_next = S_DRAIN;
      S_DRAIN:        if (w_rcvd_last || w_wdog_exp) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      S_RUN: begin
        busy  = 1'b1;
        wr_en = !full && (r_sent < r_num) && !w_q_full;
        rd_en = !empty && !w_q_empty;
      end
      S_DRAIN: begin
        busy  = 1'b1;
        rd_en = !empty && !w_q_empty;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: LFSR, expected-result queue, transaction and score counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num  <= '0;
      r_sent <= '0;
      r_rcvd <= '0;
      r_pass <= '0;
      r_fail <= '0;
      r_lfsr <= 8'h01;
      r_q    <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else if (w_accept) begin
      r_num  <= num_txn;
      r_sent <= '0;
      r_rcvd <= '0;
      r_pass <= '0;
      r_fail <= '0;
      r_lfsr <= (seed == 8'h00) ? 8'h01 : seed;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wptr] <= din[1] ^ din[0];
        r_wptr      <= r_wptr + 1'b1;
        r_lfsr      <= w_lfsr_next;
        r_sent      <= r_sent + 1'b1;
      end
      // Pop always sees the pre-push head, so same-cycle push/pop never aliases.
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_rcvd <= r_rcvd + 1'b1;
        if (w_match) begin
          if (r_pass != '1) r_pass <= r_pass + 1'b1;
        end else begin
          if (r_fail != '1) r_fail <= r_fail + 1'b1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign pass_cnt = r_pass;
  assign fail_cnt = r_fail;

endmodule

// File: tb/tb_xor_txn_master.sv
// Bench for xor_txn_master: an XOR-FIFO model with optional fault injection drives the DUT,
// and each scenario task checks counters and the written operand stream against LFSR rules.
module tb_xor_txn_master;

  localparam int CNT_W = 16;
  localparam int QD    = 4;

  logic             clk, rst, start, full, empty, dout;
  logic [CNT_W-1:0] num_txn;
  logic [7:0]       seed;
  logic             wr_en, rd_en, busy, done, timeout;
  logic [1:0]       din;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  xor_txn_master #(.CNT_W(CNT_W), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .start(start), .num_txn(num_txn), .seed(seed),
    .wr_en(wr_en), .din(din), .full(full), .rd_en(rd_en), .dout(dout), .empty(empty),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Result-FIFO model state. mode: 0 ideal, 1 invert every third, 2 drop result drop_at.
  bit   rq[$];
  logic [1:0] wlog[$];
  int   mode = 0, drop_at = 0, push_idx = 0, max_cnt = 0;
  int   n_wr = 0, n_rd = 0, viol = 0;
  int   m_cnt = 0;
  logic m_head = 1'b0;
  logic s_wr = 1'b0, s_rd = 1'b0;
  logic [1:0] s_din = 2'b00;
  logic full_force = 1'b0, stall = 1'b0, rand_bp = 1'b0, rnd_full = 1'b0, rnd_stall = 1'b0;

  assign full  = full_force | (rand_bp & rnd_full);
  assign empty = stall | (rand_bp & rnd_stall) | (m_cnt == 0);
  assign dout  = m_head;

  always @(negedge clk) begin
    s_wr = wr_en; s_rd = rd_en; s_din = din;
    if (wr_en && full) viol++;
    if (wr_en) n_wr++;
    if (rd_en) n_rd++;
  end

  always @(posedge clk) begin
    bit r;
    if (rst) rq.delete();
    else begin
      if (s_rd && rq.size() > 0) void'(rq.pop_front());
      if (s_wr) begin
        push_idx++;
        wlog.push_back(s_din);
        r = s_din[1] ^ s_din[0];
        if (mode == 1 && push_idx % 3 == 0) r = ~r;
        if (!(mode == 2 && push_idx == drop_at)) rq.push_back(r);
      end
    end
    if (rq.size() > max_cnt) max_cnt = rq.size();
    m_cnt  <= rq.size();
    m_head <= (rq.size() > 0) ? rq[0] : 1'b0;
  end

  always @(posedge clk) begin
    #1;
    rnd_full  = ($urandom_range(0, 3) == 0);
    rnd_stall = ($urandom_range(0, 2) == 0);
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] sd, input int n);
    @(posedge clk); #1;
    wlog.delete(); push_idx = 0; max_cnt = 0;
    start = 1'b1; seed = sd; num_txn = CNT_W'(n);
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; seed = 8'h00; num_txn = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({wr_en, rd_en, busy, done, timeout} !== 5'b0) begin n_bad++; $display("FAIL reset_strobes got=%b exp=00000", {wr_en, rd_en, busy, done, timeout}); end
    n_cmp++; if (pass_cnt !== 0 || fail_cnt !== 0) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", pass_cnt, fail_cnt); end
    n_cmp++; if (din !== 2'b01) begin n_bad++; $display("FAIL reset_lfsr got=%b exp=01", din); end
    rst = 1'b0;
  endtask

  task automatic test_ideal();
    bit ok; logic [7:0] v;
    mode = 0;
    pulse_start(8'hA5, 10);
    wait_done(500, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ideal_done got=0 exp=1"); end
    n_cmp++; if (wlog.size() !== 10) begin n_bad++; $display("FAIL ideal_writes got=%0d exp=10", wlog.size()); end
    v = 8'hA5;
    foreach (wlog[i]) begin
      n_cmp++; if (wlog[i] !== v[1:0]) begin n_bad++; $display("FAIL ideal_din[%0d] got=%b exp=%b", i, wlog[i], v[1:0]); end
      v = lfsr_step(v);
    end
    n_cmp++; if (pass_cnt !== 10 || fail_cnt !== 0) begin n_bad++; $display("FAIL ideal_cnt got=%0d/%0d exp=10/0", pass_cnt, fail_cnt); end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (!done || pass_cnt !== 10 || timeout !== 1'b0) begin n_bad++; $display("FAIL done_hold got=%b/%0d/%b exp=1/10/0", done, pass_cnt, timeout); end
  endtask

  task automatic test_invert();
    bit ok;
    mode = 1;
    pulse_start(8'h3C, 9);
    wait_done(500, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL invert_done got=0 exp=1"); end
    n_cmp++; if (pass_cnt !== 6 || fail_cnt !== 3) begin n_bad++; $display("FAIL invert_cnt got=%0d/%0d exp=6/3", pass_cnt, fail_cnt); end
    mode = 0;
  endtask

  task automatic test_full();
    bit ok; int sz; logic [7:0] v;
    viol = 0;
    pulse_start(8'h00, 8);
    for (int i = 0; i < 100 && wlog.size() < 3; i++) begin @(posedge clk); #1; end
    full_force = 1'b1;
    sz = wlog.size();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (wlog.size() !== sz) begin n_bad++; $display("FAIL full_hold got=%0d exp=%0d", wlog.size(), sz); end
    full_force = 1'b0;
    wait_done(500, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_done got=0 exp=1"); end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL full_viol got=%0d exp=0", viol); end
    n_cmp++; if (wlog.size() !== 8) begin n_bad++; $display("FAIL full_writes got=%0d exp=8", wlog.size()); end
    v = 8'h01;
    foreach (wlog[i]) begin
      n_cmp++; if (wlog[i] !== v[1:0]) begin n_bad++; $display("FAIL full_din[%0d] got=%b exp=%b", i, wlog[i], v[1:0]); end
      v = lfsr_step(v);
    end
    n_cmp++; if (pass_cnt !== 8) begin n_bad++; $display("FAIL full_pass got=%0d exp=8", pass_cnt); end
  endtask

  task automatic test_stall();
    bit ok; int rd0; logic [7:0] v;
    stall = 1'b1;
    pulse_start(8'h5A, 10);
    rd0 = n_rd;
    repeat (15) @(posedge clk);
    // A start while busy must be ignored.
    #1 start = 1'b1; seed = 8'h11; num_txn = 3;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    n_cmp++; if (wlog.size() !== QD || max_cnt !== QD) begin n_bad++; $display("FAIL stall_outstanding got=%0d/%0d exp=%0d", wlog.size(), max_cnt, QD); end
    n_cmp++; if (n_rd !== rd0) begin n_bad++; $display("FAIL stall_reads got=%0d exp=%0d", n_rd - rd0, 0); end
    stall = 1'b0;
    wait_done(500, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_done got=0 exp=1"); end
    n_cmp++; if (pass_cnt !== 10 || wlog.size() !== 10) begin n_bad++; $display("FAIL stall_pass got=%0d/%0d exp=10/10", pass_cnt, wlog.size()); end
    v = 8'h5A;
    foreach (wlog[i]) begin
      n_cmp++; if (wlog[i] !== v[1:0]) begin n_bad++; $display("FAIL stall_din[%0d] got=%b exp=%b", i, wlog[i], v[1:0]); end
      v = lfsr_step(v);
    end
  endtask

  task automatic test_zero();
    int wr0, rd0;
    do_reset();
    wr0 = n_wr; rd0 = n_rd;
    pulse_start(8'h33, 0);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_done got=%b/%b exp=1/0", done, busy); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (n_wr !== wr0 || n_rd !== rd0) begin n_bad++; $display("FAIL zero_pulses got=%0d/%0d exp=0/0", n_wr - wr0, n_rd - rd0); end
  endtask

  task automatic test_rst_midrun();
    pulse_start(8'hC3, 50);
    for (int i = 0; i < 200 && wlog.size() < 5; i++) begin @(posedge clk); #1; end
    n_cmp++; if (wlog.size() < 5) begin n_bad++; $display("FAIL midrun_writes got=%0d exp=5", wlog.size()); end
    rst = 1'b1; start = 1'b1; seed = 8'h77; num_txn = 5;
    @(posedge clk); #1;
    n_cmp++; if ({wr_en, rd_en, busy, done, timeout} !== 5'b0) begin n_bad++; $display("FAIL midrun_strobes got=%b exp=00000", {wr_en, rd_en, busy, done, timeout}); end
    n_cmp++; if (pass_cnt !== 0 || fail_cnt !== 0 || din !== 2'b01) begin n_bad++; $display("FAIL midrun_state got=%0d/%0d/%b exp=0/0/01", pass_cnt, fail_cnt, din); end
    start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_random();
    bit ok; int n; logic [7:0] sd, v;
    rand_bp = 1'b1; viol = 0;
    for (int r = 0; r < 6; r++) begin
      sd = (r == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      n  = $urandom_range(1, 25);
      pulse_start(sd, n);
      wait_done(3000, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_done got=0 exp=1", r); end
      n_cmp++; if (pass_cnt !== n || fail_cnt !== 0 || wlog.size() !== n) begin n_bad++; $display("FAIL rand%0d_cnt got=%0d/%0d/%0d exp=%0d/0/%0d", r, pass_cnt, fail_cnt, wlog.size(), n, n); end
      v = (sd == 8'h00) ? 8'h01 : sd;
      foreach (wlog[i]) begin
        n_cmp++; if (wlog[i] !== v[1:0]) begin n_bad++; $display("FAIL rand%0d_din[%0d] got=%b exp=%b", r, i, wlog[i], v[1:0]); end
        v = lfsr_step(v);
      end
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL rand_viol got=%0d exp=0", viol); end
    rand_bp = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    mode = 2; drop_at = 4;
    pulse_start(8'h96, 4);
`ifdef XOR_TXN_TIMEOUT_EN
    wait_done(800, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wdog_done got=0 exp=1"); end
    n_cmp++; if (timeout !== 1'b1 || pass_cnt !== 3 || fail_cnt !== 0) begin n_bad++; $display("FAIL wdog_state got=%b/%0d/%0d exp=1/3/0", timeout, pass_cnt, fail_cnt); end
`else
    wait_done(300, ok);
    n_cmp++; if (ok || busy !== 1'b1 || timeout !== 1'b0) begin n_bad++; $display("FAIL drain_wait got=%b/%b/%b exp=0/1/0", done, busy, timeout); end
    do_reset();
`endif
    mode = 0;
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_invert();
    test_full();
    test_stall();
    test_zero();
    test_rst_midrun();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
